alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle execute sequencer for the 16-bit XM datapath. Accepts one decoded instruction class per transaction and steps register-file reads, ALU source selection (constant, immediate, offset or register), the optional memory access and writeback. It drives the ALU source-selector select lines directly. A watchdog bounds memory waits.

## Interface
- `WORD_SIZE`, default 16: datapath width. Not used internally; kept for package consistency.
- `MEM_TIMEOUT`, default 15: maximum MEM cycles without `mem_ack` before a fault. Legal range is 1–255.
- `clk` in 1: the block's only clock. All state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: decoded instruction valid. Accepted only while `ready`=1.
- `op_class` in 3: 0 REG, 1 CONST, 2 IMM, 3 OFFSET; 4–7 are illegal. Sampled with `start`.
- `is_store` in 1: meaningful for OFFSET only. Sampled with `start`.
- `mem_ack` in 1: memory completion, 1 cycle, checked only in MEM.
- `ready` out 1: block is in IDLE.
- `src_rd_en`, `dst_rd_en` out 1: register-file read strobes.
- `const_sel`, `imm_val_sel`, `offset_sel` out 1: ALU source selects. At most one is high. All low selects the register file.
- `alu_en` out 1: ALU result capture.
- `mem_req` out 1: memory request level.
- `wb_en` out 1: register writeback.
- `done` out 1: end-of-transaction pulse.
- `fault` out 1: qualifies `done` (illegal class or timeout).

## Operation
- Moore FSM. All outputs decode from registered state and the latched class only, with no combinational input-to-output path.
- States and transitions:
  - IDLE → FETCH on `start`.
  - FETCH → EXEC for a legal class; FETCH → WB with fault latched for an illegal class.
  - EXEC → MEM for OFFSET; EXEC → WB otherwise.
  - MEM → WB on `mem_ack` or on timeout.
  - WB → IDLE.
- Outputs by state:
  - FETCH: `src_rd_en`=1 and `dst_rd_en`=1.
  - EXEC: `alu_en`=1, plus the select for the latched class: CONST→`const_sel`, IMM→`imm_val_sel`, OFFSET→`offset_sel`, REG→none.
  - MEM: `mem_req`=1, held until exit.
  - WB: `done`=1 and `fault`=latched fault.
  - `wb_en`=1 in WB only when there is no fault and the transaction is not an OFFSET store.
- Watchdog:
  - 8-bit counter, cleared on MEM entry, incremented each MEM cycle without ack.
  - Timeout fires when the count equals `MEM_TIMEOUT`-1 and `mem_ack`=0. The block then goes to WB with fault latched.
  - `mem_ack` in the expiry cycle wins: the transaction completes with no fault.
- `op_class`, `is_store` and the fault flag are latched. `op_class` and `is_store` are captured at accept. The fault flag is cleared at accept.
- Once accepted, a transaction runs to completion.
- `start` outside IDLE is ignored and not queued.

## Timing
- Reset:
  - `rst`=1 at an edge forces IDLE, counter=0, latched fault=0.
  - Outputs after reset: `ready`=1, all others 0.
  - Reset mid-transaction aborts it: no `done`, no `wb_en`.
- Accept at edge N: FETCH in cycle N+1, EXEC in N+2.
- REG/CONST/IMM: WB in N+3 (`done`, `wb_en`), `ready` again in N+4. Throughput is 1 instruction per 4 cycles.
- OFFSET: MEM from N+3. With ack in cycle N+3+k, WB is at N+4+k.
- Illegal class: WB in N+2 with `done`=1, `fault`=1, `wb_en`=0. No select, `alu_en` or `mem_req` is ever asserted.
- `mem_ack` outside MEM is ignored.

## Structure
- Shared package `xm_seq_pkg` holds:
  - `op_class_t` enum (REG, CONST, IMM, OFFSET).
  - `seq_state_t` enum (IDLE, FETCH, EXEC, MEM, WB).
  - Localparam `SEQ_CNT_W`=8.
- Natural sub-module: `mem_watchdog` (counter with clear, enable and expire compare). The FSM and output decode stay in the top module.

## Test plan
- Reset with `start`=1 held → `ready`=1, all other outputs 0. First accept happens at the first edge after `rst` drops.
- IMM accepted at edge 0 → `src_rd_en`/`dst_rd_en` in cycle 1; `imm_val_sel`=1 with `alu_en` in cycle 2; `done`+`wb_en` in cycle 3; `ready` in cycle 4. Repeat for CONST, REG (no select) and check each select is one-hot.
- OFFSET load, `mem_ack` in the 3rd MEM cycle → `mem_req` high for 3 cycles, `offset_sel` only in EXEC, WB with `wb_en`=1 and `fault`=0. The same sequence with `is_store`=1 gives `wb_en`=0.
- OFFSET with no ack, `MEM_TIMEOUT`=4 → exactly 4 `mem_req` cycles, then `done`=1, `fault`=1, `wb_en`=0. With ack in exactly the 4th cycle, `fault`=0.
- `op_class`=6 → `done`+`fault` at cycle 2 with no select, `alu_en` or `mem_req`. `start` pulses mid-transaction are ignored.
- `rst` asserted in MEM → next cycle IDLE with no `done`. A following REG transaction completes normally.

Source files
------------

// File: rtl/xm_seq_pkg.sv
// Shared types for the XM execute sequencer: instruction classes, FSM states
// and the watchdog counter width.
package xm_seq_pkg;

  localparam int SEQ_CNT_W = 8;

  typedef enum logic [1:0] {
    OP_REG    = 2'd0,
    OP_CONST  = 2'd1,
    OP_IMM    = 2'd2,
    OP_OFFSET = 2'd3
  } op_class_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_watchdog.sv
// Memory-wait watchdog: counts MEM cycles without an ack and flags the cycle
// in which the count reaches LIMIT-1.
module mem_watchdog
  import xm_seq_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle execute sequencer for the 16-bit XM datapath. Moore FSM whose
// outputs are registered alongside the state so no input reaches an output.
module alu_op_sequencer
  import xm_seq_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op_class,
  input  logic       is_store,
  input  logic       mem_ack,
  output logic       ready,
  output logic       src_rd_en,
  output logic       dst_rd_en,
  output logic       const_sel,
  output logic       imm_val_sel,
  output logic       offset_sel,
  output logic       alu_en,
  output logic       mem_req,
  output logic       wb_en,
  output logic       done,
  output logic       fault
);

  // WORD_SIZE does not shape this block; it is referenced only so the parameter is not dangling.
  localparam int WD_W = SEQ_CNT_W + 0 * WORD_SIZE;

  seq_state_t state;
  op_class_t  cls;
  logic       store;
  logic       illegal;
  logic       expired;

  mem_watchdog #(
    .CNT_W (WD_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_EXEC),
    .en      ((state == S_MEM) && !mem_ack),
    .expired (expired)
  );

  // Each transition also loads the output pattern of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cls         <= OP_REG;
      store       <= 1'b0;
      illegal     <= 1'b0;
      ready       <= 1'b1;
      src_rd_en   <= 1'b0;
      dst_rd_en   <= 1'b0;
      const_sel   <= 1'b0;
      imm_val_sel <= 1'b0;
      offset_sel  <= 1'b0;
      alu_en      <= 1'b0;
      mem_req     <= 1'b0;
      wb_en       <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      ready       <= 1'b0;
      src_rd_en   <= 1'b0;
      dst_rd_en   <= 1'b0;
      const_sel   <= 1'b0;
      imm_val_sel <= 1'b0;
      offset_sel  <= 1'b0;
      alu_en      <= 1'b0;
      mem_req     <= 1'b0;
      wb_en       <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            cls       <= op_class_t'(op_class[1:0]);
            store     <= is_store;
            illegal   <= op_class[2];
            src_rd_en <= 1'b1;
            dst_rd_en <= 1'b1;
          end else begin
            ready <= 1'b1;
          end
        end
        S_FETCH: begin
          if (illegal) begin
            state <= S_WB;
            done  <= 1'b1;
            fault <= 1'b1;
          end else begin
            state       <= S_EXEC;
            alu_en      <= 1'b1;
            const_sel   <= (cls == OP_CONST);
            imm_val_sel <= (cls == OP_IMM);
            offset_sel  <= (cls == OP_OFFSET);
          end
        end
        S_EXEC: begin
          if (cls == OP_OFFSET) begin
            state   <= S_MEM;
            mem_req <= 1'b1;
          end else begin
            state <= S_WB;
            done  <= 1'b1;
            wb_en <= 1'b1;
          end
        end
        S_MEM: begin
          // An ack arriving in the expiry cycle takes priority over the timeout.
          if (mem_ack || expired) begin
            state <= S_WB;
            done  <= 1'b1;
            fault <= !mem_ack;
            wb_en <= mem_ack && !store;
          end else begin
            mem_req <= 1'b1;
          end
        end
        S_WB: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a transaction-level model predicts
// per-transaction latency and output activity; a negedge monitor checks them.
module tb_alu_op_sequencer;
  import xm_seq_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op_class;
  logic       is_store;
  logic       mem_ack;
  logic       ready, src_rd_en, dst_rd_en, const_sel, imm_val_sel, offset_sel;
  logic       alu_en, mem_req, wb_en, done, fault;
  logic [10:0] out_vec;

  localparam int IDLE_VEC = 11'h400;

  alu_op_sequencer #(
    .WORD_SIZE   (16),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_class    (op_class),
    .is_store    (is_store),
    .mem_ack     (mem_ack),
    .ready       (ready),
    .src_rd_en   (src_rd_en),
    .dst_rd_en   (dst_rd_en),
    .const_sel   (const_sel),
    .imm_val_sel (imm_val_sel),
    .offset_sel  (offset_sel),
    .alu_en      (alu_en),
    .mem_req     (mem_req),
    .wb_en       (wb_en),
    .done        (done),
    .fault       (fault)
  );

  assign out_vec = {ready, src_rd_en, dst_rd_en, const_sel, imm_val_sel, offset_sel,
                    alu_en, mem_req, wb_en, done, fault};

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int lat;
    int fault_cyc;
    int wb_cyc;
    int mem_cyc;
    int src_cyc;
    int dst_cyc;
    int alu_cyc;
    int csel_cyc;
    int isel_cyc;
    int osel_cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  // Reference: what one transaction should look like end to end, from the class
  // and the MEM cycle (1-based, 0 = never) in which the ack is offered.
  function automatic exp_t model(input int cls, input bit st, input int ack);
    exp_t e;
    bit   acked;
    e.src_cyc = 1; e.dst_cyc = 1;
    e.alu_cyc = 0; e.csel_cyc = 0; e.isel_cyc = 0; e.osel_cyc = 0;
    e.mem_cyc = 0; e.fault_cyc = 0; e.wb_cyc = 0;
    if (cls > 3) begin
      e.lat = 2;
      e.fault_cyc = 1;
    end else begin
      e.alu_cyc  = 1;
      e.csel_cyc = (cls == 1) ? 1 : 0;
      e.isel_cyc = (cls == 2) ? 1 : 0;
      e.osel_cyc = (cls == 3) ? 1 : 0;
      if (cls == 3) begin
        acked       = (ack >= 1) && (ack <= TO);
        e.mem_cyc   = acked ? ack : TO;
        e.lat       = 3 + e.mem_cyc;
        e.fault_cyc = acked ? 0 : 1;
        e.wb_cyc    = (acked && !st) ? 1 : 0;
      end else begin
        e.lat    = 3;
        e.wb_cyc = 1;
      end
    end
    return e;
  endfunction

  // Monitor: accumulates output activity between accept and done.
  bit busy = 0;
  int cyc, n_src, n_dst, n_alu, n_csel, n_isel, n_osel, n_mem, n_wb, n_fault, n_multi;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy = 0;
    end else begin
      if (busy) begin
        cyc++;
        n_src   += int'(src_rd_en);
        n_dst   += int'(dst_rd_en);
        n_alu   += int'(alu_en);
        n_csel  += int'(const_sel);
        n_isel  += int'(imm_val_sel);
        n_osel  += int'(offset_sel);
        n_mem   += int'(mem_req);
        n_wb    += int'(wb_en);
        n_fault += int'(fault);
        if (int'(const_sel) + int'(imm_val_sel) + int'(offset_sel) > 1) n_multi++;
        if (done) begin
          busy = 0;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected done: got done=1, expected no transaction pending");
          end else begin
            e = exp_q.pop_front();
            checkOutput("latency",     cyc,     e.lat);
            checkOutput("fault",       n_fault, e.fault_cyc);
            checkOutput("wb_en",       n_wb,    e.wb_cyc);
            checkOutput("mem_req",     n_mem,   e.mem_cyc);
            checkOutput("src_rd_en",   n_src,   e.src_cyc);
            checkOutput("dst_rd_en",   n_dst,   e.dst_cyc);
            checkOutput("alu_en",      n_alu,   e.alu_cyc);
            checkOutput("const_sel",   n_csel,  e.csel_cyc);
            checkOutput("imm_val_sel", n_isel,  e.isel_cyc);
            checkOutput("offset_sel",  n_osel,  e.osel_cyc);
            checkOutput("select one-hot", n_multi, 0);
          end
        end
      end else if (done) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL done while idle: got done=1, expected 0");
      end
      if (ready && start) begin
        busy = 1;
        cyc = 0; n_src = 0; n_dst = 0; n_alu = 0; n_csel = 0; n_isel = 0;
        n_osel = 0; n_mem = 0; n_wb = 0; n_fault = 0; n_multi = 0;
      end
    end
  end

  task automatic waitReady();
    for (int i = 0; i < 40 && !ready; i++) @(posedge clk) #1;
    if (!ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ready timeout: got ready=0, expected 1 within 40 cycles");
      printSummary();
      $finish;
    end
  endtask

  // One transaction with ignored start/mem_ack noise outside the cycles where they matter.
  task automatic applyStimulus(input int cls, input bit st, input int ack);
    exp_t e;
    bit   noise_ack;
    waitReady();
    e = model(cls, st, ack);
    op_class = 3'(cls);
    is_store = st;
    start    = 1'b1;
    exp_q.push_back(e);
    @(posedge clk) #1;
    for (int c = 1; c <= e.lat; c++) begin
      start     = 1'($urandom_range(0, 1));
      op_class  = 3'($urandom_range(0, 7));
      is_store  = 1'($urandom_range(0, 1));
      noise_ack = ($urandom_range(0, 2) == 0) && (c <= 2 || c == e.lat);
      mem_ack   = ((cls == 3) && (ack > 0) && (c == 2 + ack)) || noise_ack;
      @(posedge clk) #1;
    end
    start   = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic resetInMem();
    waitReady();
    op_class = 3'd3;
    is_store = 1'b0;
    start    = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (3) @(posedge clk) #1;
    checkOutput("mem_req before abort", int'(mem_req), 1);
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    checkOutput("outputs after abort", int'(out_vec), IDLE_VEC);
    @(posedge clk) #1;
    checkOutput("idle after abort", int'(out_vec), IDLE_VEC);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    op_class = 3'd2;
    is_store = 1'b0;
    mem_ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", int'(out_vec), IDLE_VEC);
    rst = 1'b0;

    applyStimulus(2, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(3, 0, 3);
    applyStimulus(3, 1, 3);
    applyStimulus(3, 0, 0);
    applyStimulus(3, 0, TO);
    applyStimulus(3, 0, TO + 1);
    applyStimulus(6, 0, 0);
    resetInMem();
    applyStimulus(0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      applyStimulus($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, TO + 1));
    end

    waitReady();
    repeat (2) @(posedge clk) #1;
    checkOutput("scoreboard drained", exp_q.size(), 0);
    printSummary();
    $finish;
  end

  initial begin
    #200000;
    compared++;
    mismatched++;
    $display("[TB] FAIL global timeout: simulation did not complete");
    printSummary();
    $finish;
  end

endmodule
